uart_cmd_parser: RTL and testbench

Sits directly downstream of the UART receiver. It consumes the received bytes and their one-cycle done strobes, frames them into fixed 4-byte command packets, and checks each packet. Valid packets update the lens-filter control registers that drive the VGA pixel pipeline. Malformed, corrupt or stalled packets are rejected and flagged.

---
 rtl/uart_cmd_parser.sv | 146 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into 4-byte command packets (AA, CMD, ARG, CHK), validates them,
// and drives the lens-filter mode/brightness registers for the VGA pixel pipeline.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned NUM_MODES      = 8,
  parameter logic [2:0]  DEF_MODE       = 3'd0,
  parameter logic [7:0]  DEF_BRIGHT     = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic [2:0] o_filter_mode,
  output logic [7:0] o_brightness,
  output logic       o_cmd_valid,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] Header     = 8'hAA;
  localparam logic [7:0] CmdSetMode = 8'h01;
  localparam logic [7:0] CmdSetBri  = 8'h02;
  localparam logic [7:0] CmdRestore = 8'h03;

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrChecksum = 2'd1;
  localparam logic [1:0] ErrBadCmd   = 2'd2;
  localparam logic [1:0] ErrTimeout  = 2'd3;

  typedef enum logic [1:0] {StIdle, StGotHdr, StGotCmd, StGotArg} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      arg_q, arg_d;
  logic [2:0]      mode_q, mode_d;
  logic [7:0]      bright_q, bright_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cmd_q    <= '0;
      arg_q    <= '0;
      mode_q   <= DEF_MODE;
      bright_q <= DEF_BRIGHT;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ErrNone;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      arg_q    <= arg_d;
      mode_q   <= mode_d;
      bright_q <= bright_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    arg_d    = arg_q;
    mode_d   = mode_q;
    bright_d = bright_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;

    // A byte arriving on the terminal count wins over the timeout.
    if (i_rx_done || state_q == StIdle || cnt_q == TermCnt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (i_rx_done) begin
      unique case (state_q)
        StIdle: begin
          if (i_rx_data == Header) state_d = StGotHdr;
        end
        StGotHdr: begin
          cmd_d   = i_rx_data;
          state_d = StGotCmd;
        end
        StGotCmd: begin
          arg_d   = i_rx_data;
          state_d = StGotArg;
        end
        StGotArg: begin
          state_d = StIdle;
          if (i_rx_data != (cmd_q ^ arg_q)) begin
            err_d  = 1'b1;
            code_d = ErrChecksum;
          end else begin
            valid_d = 1'b1;
            code_d  = ErrNone;
            case (cmd_q)
              CmdSetMode: begin
                if (32'(arg_q) < NUM_MODES) begin
                  mode_d = arg_q[2:0];
                end else begin
                  valid_d = 1'b0;
                  err_d   = 1'b1;
                  code_d  = ErrBadCmd;
                end
              end
              CmdSetBri:  bright_d = arg_q;
              CmdRestore: begin
                mode_d   = DEF_MODE;
                bright_d = DEF_BRIGHT;
              end
              default: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
                code_d  = ErrBadCmd;
              end
            endcase
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && cnt_q == TermCnt) begin
      state_d = StIdle;
      err_d   = 1'b1;
      code_d  = ErrTimeout;
    end
  end

  assign o_filter_mode = mode_q;
  assign o_brightness  = bright_q;
  assign o_cmd_valid   = valid_q;
  assign o_err         = err_q;
  assign o_err_code    = code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: packet accept/reject paths, timeout, and async reset.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_done = 1'b0;
  logic [2:0] o_filter_mode;
  logic [7:0] o_brightness;
  logic       o_cmd_valid;
  logic       o_err;
  logic [1:0] o_err_code;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(100),
    .NUM_MODES     (8),
    .DEF_MODE      (3'd0),
    .DEF_BRIGHT    (8'h80)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .o_filter_mode(o_filter_mode),
    .o_brightness (o_brightness),
    .o_cmd_valid  (o_cmd_valid),
    .o_err        (o_err),
    .o_err_code   (o_err_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; strobes one byte across the next posedge, returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  // Sends four bytes back to back; on return the result pulse of the CHK byte is visible.
  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send_byte(8'hAA);
    send_byte(c);
    send_byte(a);
    send_byte(k);
  endtask

  task automatic check_out(input string tag, input logic [2:0] mode, input logic [7:0] bri,
                           input logic vld, input logic err, input logic [1:0] code);
    check_eq({tag, ".mode"}, 32'(o_filter_mode), 32'(mode));
    check_eq({tag, ".bright"}, 32'(o_brightness), 32'(bri));
    check_eq({tag, ".valid"}, 32'(o_cmd_valid), 32'(vld));
    check_eq({tag, ".err"}, 32'(o_err), 32'(err));
    check_eq({tag, ".code"}, 32'(o_err_code), 32'(code));
  endtask

  initial begin
    int n;
    logic saw_err;

    #12;
    check_out("reset", 3'd0, 8'h80, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // SET_MODE 5
    send_pkt(8'h01, 8'h05, 8'h04);
    check_out("mode5", 3'd5, 8'h80, 1'b1, 1'b0, 2'd0);
    // SET_BRIGHT 3C, then immediately an illegal mode
    send_pkt(8'h02, 8'h3C, 8'h3E);
    check_out("bri3c", 3'd5, 8'h3C, 1'b1, 1'b0, 2'd0);
    send_pkt(8'h01, 8'h09, 8'h08);
    check_out("badarg", 3'd5, 8'h3C, 1'b0, 1'b1, 2'd2);
    @(negedge clk);
    check_out("badarg_hold", 3'd5, 8'h3C, 1'b0, 1'b0, 2'd2);

    // Bad checksum, then RESTORE
    send_pkt(8'h01, 8'h02, 8'hFF);
    check_out("badchk", 3'd5, 8'h3C, 1'b0, 1'b1, 2'd1);
    @(negedge clk);
    send_pkt(8'h03, 8'h00, 8'h03);
    check_out("restore", 3'd0, 8'h80, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    check_eq("valid_one_cycle", 32'(o_cmd_valid), 32'd0);

    // Leading junk ignored
    send_byte(8'h55);
    send_byte(8'h13);
    check_eq("junk.err", 32'(o_err), 32'd0);
    check_eq("junk.code", 32'(o_err_code), 32'd0);
    send_pkt(8'h01, 8'h03, 8'h02);
    check_out("mode3", 3'd3, 8'h80, 1'b1, 1'b0, 2'd0);
    @(negedge clk);

    // Timeout after AA 01
    send_byte(8'hAA);
    send_byte(8'h01);
    n = 0;
    while (!o_err && n < 150) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout.cycles", 32'(n), 32'd100);
    check_eq("timeout.code", 32'(o_err_code), 32'd3);
    check_eq("timeout.mode", 32'(o_filter_mode), 32'd3);
    @(negedge clk);
    check_eq("timeout.pulse", 32'(o_err), 32'd0);
    send_pkt(8'h01, 8'h01, 8'h00);
    check_out("after_to", 3'd1, 8'h80, 1'b1, 1'b0, 2'd0);
    @(negedge clk);

    // Byte arriving exactly on the terminal count
    send_byte(8'hAA);
    send_byte(8'h01);
    saw_err = 1'b0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (o_err) saw_err = 1'b1;
    end
    send_byte(8'h02);
    if (o_err) saw_err = 1'b1;
    send_byte(8'h03);
    check_eq("term.no_err", 32'(saw_err), 32'd0);
    check_out("term", 3'd2, 8'h80, 1'b1, 1'b0, 2'd0);
    @(negedge clk);

    // Reset mid-packet
    send_pkt(8'h02, 8'h44, 8'h46);
    check_out("bri44", 3'd2, 8'h44, 1'b1, 1'b0, 2'd0);
    send_pkt(8'h02, 8'h10, 8'h00);
    check_out("badchk2", 3'd2, 8'h44, 1'b0, 1'b1, 2'd1);
    send_byte(8'hAA);
    send_byte(8'h01);
    #2 reset = 1'b0;
    #1;
    check_out("midrst", 3'd0, 8'h80, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h04);
    check_out("stale", 3'd0, 8'h80, 1'b0, 1'b0, 2'd0);
    send_pkt(8'h01, 8'h04, 8'h05);
    check_out("mode4", 3'd4, 8'h80, 1'b1, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
